block_refill_unit: RTL and testbench

Memory-side refill/writeback engine between the cache and a word-wide backing memory. It serves cache misses by fetching a whole block one word at a time and presenting it to the cache with `block_ready`. It also drains dirty blocks from the cache to memory one word at a time. Single outstanding operation; writeback has priority over refill.

---
 rtl/cache_pkg.sv | 30 +++
 rtl/block_refill_unit_if.sv | 46 ++++
 rtl/block_word_buffer.sv | 45 ++++
 rtl/block_refill_unit.sv | 150 +++++++++++++++
 tb/tb_block_refill_unit.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache memory-side blocks.
package cache_pkg;

    localparam int unsigned DEF_WORD_SIZE             = 16;
    localparam int unsigned DEF_NUM_OF_WORDS_IN_BLOCK = 16;
    localparam int unsigned DEF_EXTERNAL_ADDR_SIZE    = 16;

    // Number of word-offset bits inside a block
    function automatic int unsigned offs(input int unsigned num_words);
        return $clog2(num_words);
    endfunction

    // Width of a whole block in bits
    function automatic int unsigned block_bits(input int unsigned word_size,
                                               input int unsigned num_words);
        return word_size * num_words;
    endfunction

    localparam int unsigned DEF_BLOCK_SIZE =
        DEF_WORD_SIZE * DEF_NUM_OF_WORDS_IN_BLOCK;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWb    = 3'd1,
        StFill  = 3'd2,
        StWdone = 3'd3,
        StRdone = 3'd4
    } state_e;

endpackage

// File: rtl/block_refill_unit_if.sv
// Cache-side and memory-side signals of the refill/writeback engine.
interface block_refill_unit_if
    import cache_pkg::*;
#(
    parameter int unsigned WORD_SIZE             = DEF_WORD_SIZE,
    parameter int unsigned NUM_OF_WORDS_IN_BLOCK = DEF_NUM_OF_WORDS_IN_BLOCK,
    parameter int unsigned EXTERNAL_ADDR_SIZE    = DEF_EXTERNAL_ADDR_SIZE
);
    localparam int unsigned BLOCK_SIZE = block_bits(WORD_SIZE, NUM_OF_WORDS_IN_BLOCK);

    // Cache side
    logic                          request_data;
    logic [EXTERNAL_ADDR_SIZE-1:0] requested_addr;
    logic                          commit_valid;
    logic [EXTERNAL_ADDR_SIZE-1:0] commit_addr;
    logic [BLOCK_SIZE-1:0]         commit_block;
    logic                          block_ready;
    logic [BLOCK_SIZE-1:0]         incoming_block;
    logic                          commit_done;
    logic                          busy;

    // Memory side
    logic                          mem_req;
    logic                          mem_we;
    logic [EXTERNAL_ADDR_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0]          mem_wdata;
    logic                          mem_ack;
    logic [WORD_SIZE-1:0]          mem_rdata;

    // View of the refill engine itself
    modport master (
        input  request_data, requested_addr, commit_valid, commit_addr, commit_block,
               mem_ack, mem_rdata,
        output block_ready, incoming_block, commit_done, busy,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    // View of the surrounding cache and memory
    modport slave (
        output request_data, requested_addr, commit_valid, commit_addr, commit_block,
               mem_ack, mem_rdata,
        input  block_ready, incoming_block, commit_done, busy,
               mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/block_word_buffer.sv
// Block-wide register with whole-block load, indexed word write and indexed word read.
module block_word_buffer
    import cache_pkg::*;
#(
    parameter int unsigned WORD_SIZE = DEF_WORD_SIZE,
    parameter int unsigned NUM_WORDS = DEF_NUM_OF_WORDS_IN_BLOCK
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          load_i,
    input  logic [block_bits(WORD_SIZE, NUM_WORDS)-1:0]   load_data_i,
    input  logic                                          wr_en_i,
    input  logic [offs(NUM_WORDS)-1:0]                    wr_idx_i,
    input  logic [WORD_SIZE-1:0]                          wr_data_i,
    input  logic [offs(NUM_WORDS)-1:0]                    rd_idx_i,
    output logic [WORD_SIZE-1:0]                          rd_data_o,
    output logic [block_bits(WORD_SIZE, NUM_WORDS)-1:0]   block_o
);
    localparam int unsigned BLOCK_SIZE = block_bits(WORD_SIZE, NUM_WORDS);

    logic [BLOCK_SIZE-1:0] block_q, block_d;

    // Whole-block load wins over a single word write
    always_comb begin
        block_d = block_q;
        if (load_i) begin
            block_d = load_data_i;
        end else if (wr_en_i) begin
            block_d[wr_idx_i*WORD_SIZE +: WORD_SIZE] = wr_data_i;
        end
    end

    // Block storage, cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            block_q <= '0;
        end else begin
            block_q <= block_d;
        end
    end

    assign rd_data_o = block_q[rd_idx_i*WORD_SIZE +: WORD_SIZE];
    assign block_o   = block_q;

endmodule

// File: rtl/block_refill_unit.sv
// Refill/writeback engine: moves whole cache blocks to and from word-wide memory.
module block_refill_unit
    import cache_pkg::*;
#(
    parameter int unsigned WORD_SIZE             = DEF_WORD_SIZE,
    parameter int unsigned NUM_OF_WORDS_IN_BLOCK = DEF_NUM_OF_WORDS_IN_BLOCK,
    parameter int unsigned EXTERNAL_ADDR_SIZE    = DEF_EXTERNAL_ADDR_SIZE
) (
    input logic                 clk,
    input logic                 rst,
    block_refill_unit_if.master bus
);
    localparam int unsigned OFFS       = offs(NUM_OF_WORDS_IN_BLOCK);
    localparam int unsigned BLOCK_SIZE = block_bits(WORD_SIZE, NUM_OF_WORDS_IN_BLOCK);
    localparam int unsigned BASE_BITS  = EXTERNAL_ADDR_SIZE - OFFS;
    localparam logic [OFFS-1:0] CNT_LAST = {OFFS{1'b1}};

    state_e                 state_q, state_d;
    logic [OFFS-1:0]        cnt_q, cnt_d;
    logic [BASE_BITS-1:0]   base_q, base_d;
    logic                   block_ready_q, block_ready_d;
    logic                   commit_done_q, commit_done_d;
    logic                   busy_q, busy_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;

    logic                   wb_load;
    logic                   fill_we;
    logic [WORD_SIZE-1:0]   wb_word;
    logic [WORD_SIZE-1:0]   fill_word_unused;
    logic [BLOCK_SIZE-1:0]  fill_block;
    logic [BLOCK_SIZE-1:0]  wb_block_unused;

    // Next state, word counter, captured block base and registered output values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        wb_load = 1'b0;
        fill_we = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Writeback has priority; a pending refill is picked up on a later IDLE
                if (bus.commit_valid) begin
                    base_d  = bus.commit_addr[EXTERNAL_ADDR_SIZE-1:OFFS];
                    cnt_d   = '0;
                    wb_load = 1'b1;
                    state_d = StWb;
                end else if (bus.request_data) begin
                    base_d  = bus.requested_addr[EXTERNAL_ADDR_SIZE-1:OFFS];
                    cnt_d   = '0;
                    state_d = StFill;
                end
            end
            StWb: begin
                if (bus.mem_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = StWdone;
                    end
                end
            end
            StFill: begin
                if (bus.mem_ack) begin
                    fill_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = StRdone;
                    end
                end
            end
            StWdone: state_d = StIdle;
            StRdone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so they line up with it
        block_ready_d = (state_d == StRdone);
        commit_done_d = (state_d == StWdone);
        busy_d        = (state_d != StIdle);
        mem_req_d     = (state_d == StWb) || (state_d == StFill);
        mem_we_d      = (state_d == StWb);
    end

    // FSM state, counter, base and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            base_q        <= '0;
            block_ready_q <= 1'b0;
            commit_done_q <= 1'b0;
            busy_q        <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            base_q        <= base_d;
            block_ready_q <= block_ready_d;
            commit_done_q <= commit_done_d;
            busy_q        <= busy_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
        end
    end

    block_word_buffer #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_WORDS (NUM_OF_WORDS_IN_BLOCK)
    ) u_fill_buf (
        .clk         (clk),
        .rst         (rst),
        .load_i      (1'b0),
        .load_data_i ('0),
        .wr_en_i     (fill_we),
        .wr_idx_i    (cnt_q),
        .wr_data_i   (bus.mem_rdata),
        .rd_idx_i    (cnt_q),
        .rd_data_o   (fill_word_unused),
        .block_o     (fill_block)
    );

    block_word_buffer #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_WORDS (NUM_OF_WORDS_IN_BLOCK)
    ) u_wb_buf (
        .clk         (clk),
        .rst         (rst),
        .load_i      (wb_load),
        .load_data_i (bus.commit_block),
        .wr_en_i     (1'b0),
        .wr_idx_i    ('0),
        .wr_data_i   ('0),
        .rd_idx_i    (cnt_q),
        .rd_data_o   (wb_word),
        .block_o     (wb_block_unused)
    );

    assign bus.block_ready    = block_ready_q;
    assign bus.commit_done    = commit_done_q;
    assign bus.busy           = busy_q;
    assign bus.mem_req        = mem_req_q;
    assign bus.mem_we         = mem_we_q;
    assign bus.incoming_block = fill_block;
    // Decoded from registered base and counter; both are zero out of reset
    assign bus.mem_addr       = {base_q, cnt_q};
    assign bus.mem_wdata      = wb_word;

endmodule

// File: tb/tb_block_refill_unit.sv
// Directed bench for block_refill_unit with a zero-latency memory model.
module tb_block_refill_unit;

    logic clk;
    logic rst;

    int n_tests;
    int n_fail;

    block_refill_unit_if #(
        .WORD_SIZE             (16),
        .NUM_OF_WORDS_IN_BLOCK (16),
        .EXTERNAL_ADDR_SIZE    (16)
    ) bus ();

    block_refill_unit #(
        .WORD_SIZE             (16),
        .NUM_OF_WORDS_IN_BLOCK (16),
        .EXTERNAL_ADDR_SIZE    (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory returns a fixed function of the address
    assign bus.mem_rdata = bus.mem_addr ^ 16'hA5A5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-run observations
    logic        busy_rec [0:127];
    logic        req_rec  [0:127];
    int          ready_cyc, ready_cnt, done_cyc, done_cnt;
    logic [15:0] xa[$];
    logic [15:0] xd[$];
    logic        xw[$];
    int          xc[$];
    logic [255:0] blk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs ncyc cycles after edge 0, acking each word after `waits` wait cycles.
    task automatic run(input int waits, input int ncyc, input bit hold_req);
        int          wcnt;
        logic [15:0] ha, hd;
        xa.delete(); xd.delete(); xw.delete(); xc.delete();
        ready_cyc = -1; ready_cnt = 0; done_cyc = -1; done_cnt = 0;
        wcnt = 0; ha = '0; hd = '0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            busy_rec[c] = bus.busy;
            req_rec[c]  = bus.mem_req;
            if (bus.block_ready) begin
                ready_cnt++;
                if (ready_cyc < 0) ready_cyc = c;
                if (!hold_req) bus.request_data = 1'b0;
            end
            if (bus.commit_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                bus.commit_valid = 1'b0;
            end
            if (bus.mem_req) begin
                if (wcnt == 0) begin
                    ha = bus.mem_addr;
                    hd = bus.mem_wdata;
                end else begin
                    check_eq("wait_addr_stable", bus.mem_addr, ha);
                    check_eq("wait_wdata_stable", bus.mem_wdata, hd);
                end
                if (wcnt < waits) begin
                    bus.mem_ack = 1'b0;
                    wcnt++;
                end else begin
                    bus.mem_ack = 1'b1;
                    wcnt = 0;
                    xa.push_back(bus.mem_addr);
                    xd.push_back(bus.mem_wdata);
                    xw.push_back(bus.mem_we);
                    xc.push_back(c);
                end
            end else begin
                bus.mem_ack = 1'b0;
                wcnt = 0;
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        bus.request_data   = 1'b0;
        bus.requested_addr = '0;
        bus.commit_valid   = 1'b0;
        bus.commit_addr    = '0;
        bus.commit_block   = '0;
        bus.mem_ack        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_mem_req", bus.mem_req, 1'b0);
        check_eq("rst_mem_we", bus.mem_we, 1'b0);
        check_eq("rst_block_ready", bus.block_ready, 1'b0);
        check_eq("rst_commit_done", bus.commit_done, 1'b0);
        check_eq("rst_mem_addr", bus.mem_addr, 16'h0);
        check_eq("rst_mem_wdata", bus.mem_wdata, 16'h0);
        check_eq("rst_incoming", bus.incoming_block, 256'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Refill, no wait states
        bus.request_data = 1'b1; bus.requested_addr = 16'h1237;
        @(posedge clk);
        run(0, 20, 1'b0);
        check_eq("fill_xfers", xa.size(), 16);
        for (int i = 0; i < 16 && i < xa.size(); i++) begin
            check_eq("fill_addr", xa[i], 16'h1230 + 16'(i));
            check_eq("fill_cycle", xc[i], i + 1);
            check_eq("fill_we", xw[i], 1'b0);
        end
        for (int c = 1; c <= 20; c++) begin
            check_eq("fill_mem_req", req_rec[c], (c >= 1 && c <= 16));
            check_eq("fill_busy", busy_rec[c], (c >= 1 && c <= 17));
        end
        check_eq("fill_ready_cyc", ready_cyc, 17);
        check_eq("fill_ready_cnt", ready_cnt, 1);
        check_eq("fill_word0", bus.incoming_block[15:0], 16'hB795);
        check_eq("fill_word15", bus.incoming_block[255:240], 16'hB79A);

        // Writeback, no wait states
        for (int i = 0; i < 16; i++) blk[i*16 +: 16] = 16'h0100 + 16'(i);
        @(negedge clk);
        bus.commit_valid = 1'b1; bus.commit_addr = 16'h00F3; bus.commit_block = blk;
        @(posedge clk);
        run(0, 20, 1'b0);
        check_eq("wb_xfers", xa.size(), 16);
        for (int i = 0; i < 16 && i < xa.size(); i++) begin
            check_eq("wb_addr", xa[i], 16'h00F0 + 16'(i));
            check_eq("wb_data", xd[i], 16'h0100 + 16'(i));
            check_eq("wb_we", xw[i], 1'b1);
        end
        check_eq("wb_done_cyc", done_cyc, 17);
        check_eq("wb_done_cnt", done_cnt, 1);
        check_eq("wb_ready_cnt", ready_cnt, 0);
        check_eq("wb_keeps_fill", bus.incoming_block[15:0], 16'hB795);

        // Refill with two wait cycles per word
        @(negedge clk);
        bus.request_data = 1'b1; bus.requested_addr = 16'h4A05;
        @(posedge clk);
        run(2, 55, 1'b0);
        check_eq("wfill_xfers", xa.size(), 16);
        for (int i = 0; i < 16 && i < xa.size(); i++)
            check_eq("wfill_addr", xa[i], 16'h4A00 + 16'(i));
        check_eq("wfill_ready_cyc", ready_cyc, 49);
        check_eq("wfill_word5", bus.incoming_block[95:80], 16'hEFA0);

        // Writeback with two wait cycles per word
        for (int i = 0; i < 16; i++) blk[i*16 +: 16] = 16'h5A00 + 16'(i);
        @(negedge clk);
        bus.commit_valid = 1'b1; bus.commit_addr = 16'h7777; bus.commit_block = blk;
        @(posedge clk);
        run(2, 55, 1'b0);
        check_eq("wwb_xfers", xa.size(), 16);
        for (int i = 0; i < 16 && i < xa.size(); i++) begin
            check_eq("wwb_addr", xa[i], 16'h7770 + 16'(i));
            check_eq("wwb_data", xd[i], 16'h5A00 + 16'(i));
        end
        check_eq("wwb_done_cyc", done_cyc, 49);

        // Both requests together: writeback first, then refill
        for (int i = 0; i < 16; i++) blk[i*16 +: 16] = 16'hC000 + 16'(i);
        @(negedge clk);
        bus.commit_valid = 1'b1; bus.commit_addr = 16'h2222; bus.commit_block = blk;
        bus.request_data = 1'b1; bus.requested_addr = 16'h3339;
        @(posedge clk);
        run(0, 40, 1'b0);
        check_eq("both_xfers", xa.size(), 32);
        for (int i = 0; i < 32 && i < xa.size(); i++) begin
            check_eq("both_we", xw[i], (i < 16));
            if (i >= 16) begin
                check_eq("both_rd_addr", xa[i], 16'h3330 + 16'(i - 16));
                check_eq("both_rd_cycle", xc[i], 19 + (i - 16));
            end
        end
        check_eq("both_done_cyc", done_cyc, 17);
        check_eq("both_ready_cyc", ready_cyc, 35);
        check_eq("both_idle_18", busy_rec[18], 1'b0);

        // Reset at word 7 of a refill
        @(negedge clk);
        bus.request_data = 1'b1; bus.requested_addr = 16'h6100;
        @(posedge clk);
        run(0, 7, 1'b0);
        @(negedge clk);
        check_eq("abort_addr_w7", bus.mem_addr, 16'h6107);
        bus.mem_ack = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("abort_mem_req", bus.mem_req, 1'b0);
        check_eq("abort_busy", bus.busy, 1'b0);
        check_eq("abort_incoming", bus.incoming_block, 256'h0);
        check_eq("abort_mem_addr", bus.mem_addr, 16'h0);
        bus.request_data = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run(0, 25, 1'b0);
        check_eq("abort_no_ready", ready_cnt, 0);
        check_eq("abort_no_done", done_cnt, 0);
        check_eq("abort_no_xfer", xa.size(), 0);

        // Request held past block_ready starts a second refill
        @(negedge clk);
        bus.request_data = 1'b1; bus.requested_addr = 16'h0BEF;
        @(posedge clk);
        run(0, 35, 1'b1);
        bus.request_data = 1'b0;
        check_eq("hold_ready_first", ready_cyc, 17);
        check_eq("hold_ready_cnt", ready_cnt, 2);
        check_eq("hold_busy_17", busy_rec[17], 1'b1);
        check_eq("hold_busy_18", busy_rec[18], 1'b0);
        check_eq("hold_busy_19", busy_rec[19], 1'b1);
        check_eq("hold_xfers", xa.size(), 32);
        run(0, 5, 1'b0);
        check_eq("hold_settled", ready_cnt, 0);
        check_eq("hold_idle", busy_rec[5], 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
